// File: rtl/lsu.sv
// lsu: single-outstanding RISC-V load/store unit with read-modify-write sub-word stores
// and a bounded wait for read data.
module lsu #(
   parameter int ADDR_W  = 13,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       rdata,
   output logic              mem_rd_en,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wr_data,
   input  logic [31:0]       mem_rd_data,
   input  logic              mem_rd_valid
);
   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR, DONE} state_t;
   state_t state, state_nx;
   logic we_q, err_q, bad, timeout;
   logic [2:0] f3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0] wdata_q, word_q, mask, merged, load;
   logic [3:0] cnt;
   logic [4:0] sh;
   logic [7:0] b;
   logic [15:0] h;
   always_comb begin
      bad = funct3 == 3'b011 || funct3[2:1] == 2'b11 || (we && funct3[2]) ||
            (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
      timeout = cnt == 4'(TIMEOUT - 1);
      state_nx = state;
      case (state)
         IDLE:    state_nx = !req ? IDLE : bad ? DONE : (we && funct3[1]) ? WR : RD_REQ;
         RD_REQ:  state_nx = RD_WAIT;
         RD_WAIT: state_nx = mem_rd_valid ? (we_q ? WR : DONE) : timeout ? DONE : RD_WAIT;
         WR:      state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= '0;
         wdata_q <= '0;
         word_q  <= '0;
         err_q   <= 1'b0;
         cnt     <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && req) begin
            we_q    <= we;
            f3_q    <= funct3;
            addr_q  <= addr;
            wdata_q <= wdata;
            err_q   <= bad;
         end
         if (state == RD_WAIT && mem_rd_valid) word_q <= mem_rd_data;
         if (state == RD_WAIT && !mem_rd_valid && timeout) err_q <= 1'b1;
         cnt <= (state == RD_WAIT && !mem_rd_valid && !timeout) ? cnt + 4'd1 : 4'd0;
      end
   // Halfword lanes rely on addr_q[0]=0, which the error check guarantees.
   always_comb begin
      sh     = {addr_q[1:0], 3'b000};
      mask   = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
      merged = f3_q[1] ? wdata_q : (word_q & ~mask) | ((wdata_q << sh) & mask);
      b      = word_q[sh +: 8];
      h      = addr_q[1] ? word_q[31:16] : word_q[15:0];
      load   = f3_q[1] ? word_q : f3_q[0] ? {{16{~f3_q[2] & h[15]}}, h} : {{24{~f3_q[2] & b[7]}}, b};
   end
   assign busy        = state != IDLE;
   assign done        = state == DONE;
   assign err         = done && err_q;
   assign mem_rd_en   = state == RD_REQ;
   assign mem_wr_en   = state == WR;
   assign mem_addr    = (state inside {RD_REQ, RD_WAIT, WR}) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign mem_wr_data = mem_wr_en ? merged : 32'd0;
   assign rdata       = (done && !we_q && !err_q) ? load : 32'd0;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed checks of lsu against a one-cycle-latency word memory model.
module tb_lsu;
   logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0;
   logic [2:0] funct3 = 3'b000;
   logic [12:0] addr = '0;
   logic [31:0] wdata = '0;
   logic busy, done, err, mem_rd_en, mem_wr_en;
   logic [31:0] rdata, mem_wr_data;
   logic [12:0] mem_addr;
   logic [31:0] mem_rd_data = '0;
   logic mem_rd_valid = 1'b0;
   logic mute = 1'b0;
   logic [31:0] mem [0:2047];
   int checks = 0, errors = 0;
   int lat, nrd, nwr, both;
   logic r_err, post_done, stray;
   logic [31:0] r_data, wd;
   logic [12:0] wa;

   lsu #(.ADDR_W(13), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .funct3(funct3), .addr(addr),
      .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_wr_en) mem[mem_addr[12:2]] <= mem_wr_data;
      mem_rd_valid <= mem_rd_en && !mute;
      mem_rd_data  <= mem[mem_addr[12:2]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request from a negedge; optionally keep req high with altered fields while busy.
   task automatic txn(input logic w, input logic [2:0] f, input logic [12:0] a,
                      input logic [31:0] d, input bit hold);
      req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
      @(posedge clk);
      #1;
      if (hold) begin we = 1'b1; funct3 = 3'b010; addr = 13'h030; wdata = 32'hFFFF_FFFF; end
      else req = 1'b0;
      lat = 0; nrd = 0; nwr = 0; both = 0; r_err = 1'b0; r_data = '0; wa = '0; wd = '0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (mem_rd_en) nrd++;
         if (mem_wr_en) begin nwr++; wa = mem_addr; wd = mem_wr_data; end
         if (mem_rd_en && mem_wr_en) both++;
         if (done) begin r_err = err; r_data = rdata; break; end
      end
      req = 1'b0;
      @(negedge clk);
      post_done = done;
   endtask

   initial begin
      #2;
      chk("reset_outputs", {27'd0, busy, done, err, mem_rd_en, mem_wr_en}, 32'd0);
      chk("reset_rdata", rdata, 32'd0);
      chk("reset_mem_addr", {19'd0, mem_addr}, 32'd0);
      chk("reset_wr_data", mem_wr_data, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      txn(1'b1, 3'b010, 13'h010, 32'h8899_AABB, 1'b0);
      chk("sw_lat", lat, 2);
      chk("sw_nrd", nrd, 0);
      chk("sw_mem", mem[4], 32'h8899_AABB);
      chk("sw_post_done", {31'd0, post_done}, 0);

      txn(1'b0, 3'b000, 13'h011, 32'd0, 1'b0);
      chk("lb_lat", lat, 3);
      chk("lb_rdata", r_data, 32'hFFFF_FFAA);
      chk("lb_err", {31'd0, r_err}, 0);
      chk("lb_nrd", nrd, 1);

      txn(1'b0, 3'b101, 13'h012, 32'd0, 1'b0);
      chk("lhu_rdata", r_data, 32'h0000_8899);
      txn(1'b0, 3'b010, 13'h010, 32'd0, 1'b0);
      chk("lw_rdata", r_data, 32'h8899_AABB);
      txn(1'b0, 3'b001, 13'h010, 32'd0, 1'b0);
      chk("lh_rdata", r_data, 32'hFFFF_AABB);
      txn(1'b0, 3'b100, 13'h010, 32'd0, 1'b0);
      chk("lbu_rdata", r_data, 32'h0000_00BB);

      txn(1'b1, 3'b000, 13'h013, 32'h1234_5655, 1'b0);
      chk("sb_lat", lat, 4);
      chk("sb_nrd", nrd, 1);
      chk("sb_nwr", nwr, 1);
      chk("sb_wa", {19'd0, wa}, 32'h010);
      chk("sb_wd", wd, 32'h5599_AABB);
      chk("sb_rdata", r_data, 32'd0);
      chk("sb_both", both, 0);
      chk("sb_mem", mem[4], 32'h5599_AABB);

      txn(1'b1, 3'b010, 13'h020, 32'hDEAD_BEEF, 1'b0);
      txn(1'b1, 3'b001, 13'h022, 32'h0000_CAFE, 1'b0);
      chk("sh_lat", lat, 4);
      chk("sh_mem", mem[8], 32'hCAFE_BEEF);

      txn(1'b0, 3'b010, 13'h006, 32'd0, 1'b0);
      chk("lw_mis_lat", lat, 1);
      chk("lw_mis_err", {31'd0, r_err}, 1);
      chk("lw_mis_mem", nrd + nwr, 0);
      txn(1'b1, 3'b100, 13'h020, 32'h1111_1111, 1'b0);
      chk("sw_f100_lat", lat, 1);
      chk("sw_f100_err", {31'd0, r_err}, 1);
      chk("sw_f100_mem", nrd + nwr, 0);
      txn(1'b0, 3'b011, 13'h010, 32'd0, 1'b0);
      chk("f011_err", {31'd0, r_err}, 1);

      mute = 1'b1;
      txn(1'b0, 3'b010, 13'h010, 32'd0, 1'b0);
      chk("to_lat", lat, 17);
      chk("to_err", {31'd0, r_err}, 1);
      chk("to_rdata", r_data, 32'd0);
      mute = 1'b0;
      txn(1'b0, 3'b010, 13'h010, 32'd0, 1'b0);
      chk("after_to_lat", lat, 3);
      chk("after_to_rdata", r_data, 32'h5599_AABB);
      chk("after_to_err", {31'd0, r_err}, 0);

      txn(1'b1, 3'b010, 13'h034, 32'h0000_0000, 1'b0);
      txn(1'b0, 3'b010, 13'h020, 32'd0, 1'b1);
      chk("busy_ign_rdata", r_data, 32'hCAFE_BEEF);
      chk("busy_ign_nwr", nwr, 0);
      chk("busy_ign_post", {31'd0, post_done}, 0);
      chk("busy_ign_busy", {31'd0, busy}, 0);

      txn(1'b1, 3'b010, 13'h040, 32'h7777_7777, 1'b0);
      req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 13'h040; wdata = 32'h1111_1111;
      @(posedge clk);
      #1 req = 1'b0;
      chk("rst_wr_active", {31'd0, mem_wr_en}, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_wr_en", {29'd0, mem_wr_en, busy, done}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      stray = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (done || mem_wr_en || busy) stray = 1'b1;
      end
      chk("rst_no_stray", {31'd0, stray}, 0);
      chk("rst_mem", mem[16], 32'h7777_7777);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
